// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives the instruction memory request, holds one
// registered instruction for decode, absorbs back-pressure with a skid slot.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] instr,
    output logic [31:0] pc_plus4,
    output logic        instr_valid
);

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        SKID    = 2'd1,
        DISCARD = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_q, pend_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc4_q, skid_pc4_d;

    logic        out_free;
    logic [31:0] pc_inc;

    // pc_q is never touched while a request is outstanding, so it doubles
    // as the held address in DISCARD.
    assign imem_req    = !reset && (state_q != SKID);
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign pc_plus4    = pc4_q;
    assign instr_valid = valid_q;

    assign out_free = !valid_q || !stall;
    assign pc_inc   = pc_q + 32'd4;

    // Next-state, pc, output-stage and skid-slot update; redirect wins.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pend_d       = pend_q;
        instr_d      = instr_q;
        pc4_d        = pc4_q;
        valid_d      = valid_q && stall;
        skid_instr_d = skid_instr_q;
        skid_pc4_d   = skid_pc4_q;
        unique case (state_q)
            FETCH: begin
                if (redirect_valid) begin
                    valid_d = 1'b0;
                    if (imem_ready) begin
                        pc_d = redirect_pc;
                    end else begin
                        pend_d  = redirect_pc;
                        state_d = DISCARD;
                    end
                end else if (imem_ready) begin
                    pc_d = pc_inc;
                    if (out_free) begin
                        instr_d = imem_rdata;
                        pc4_d   = pc_inc;
                        valid_d = 1'b1;
                    end else begin
                        skid_instr_d = imem_rdata;
                        skid_pc4_d   = pc_inc;
                        state_d      = SKID;
                    end
                end
            end
            SKID: begin
                if (redirect_valid) begin
                    valid_d      = 1'b0;
                    pc_d         = redirect_pc;
                    skid_instr_d = 32'd0;
                    skid_pc4_d   = 32'd0;
                    state_d      = FETCH;
                end else if (!stall) begin
                    instr_d = skid_instr_q;
                    pc4_d   = skid_pc4_q;
                    valid_d = 1'b1;
                    state_d = FETCH;
                end
            end
            DISCARD: begin
                valid_d = 1'b0;
                if (redirect_valid) begin
                    pend_d = redirect_pc;
                end
                if (imem_ready) begin
                    pc_d    = redirect_valid ? redirect_pc : pend_q;
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            pend_q       <= 32'd0;
            instr_q      <= 32'd0;
            pc4_q        <= 32'd0;
            valid_q      <= 1'b0;
            skid_instr_q <= 32'd0;
            skid_pc4_q   <= 32'd0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pend_q       <= pend_d;
            instr_q      <= instr_d;
            pc4_q        <= pc4_d;
            valid_q      <= valid_d;
            skid_instr_q <= skid_instr_d;
            skid_pc4_q   <= skid_pc4_d;
        end
    end

endmodule
